// File: rtl/rubiks_polibot_pkg.sv
// Shared definitions for the move sequencer: FSM state encoding and default terminator code.
package rubiks_polibot;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        LE       = 3'd1,
        VERIFICA = 3'd2,
        ACIONA   = 3'd3,
        ESPERA   = 3'd4,
        PAUSADO  = 3'd5,
        FIM      = 3'd6
    } estado_t;

    localparam int unsigned END_CODE_PADRAO = 0;

endpackage

// File: rtl/ram_sincrona.sv
// Move storage: one write port, one registered read port, array without reset.
module ram_sincrona #(
    parameter int unsigned DEPTH  = 480,
    parameter int unsigned MOVE_W = 3,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [MOVE_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [MOVE_W-1:0] rd_data
);

    logic [MOVE_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/sequenciador_movimentos.sv
// Stores a list of move codes and replays them to the servo manager, one handshake per move.
module sequenciador_movimentos
    import rubiks_polibot::*;
#(
    parameter int unsigned DEPTH    = 480,
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned MOVE_W   = 3,
    parameter int unsigned END_CODE = END_CODE_PADRAO
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              zera,
    input  logic              wr_valid,
    input  logic [MOVE_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              iniciar,
    input  logic              modo_passo,
    input  logic              pausa,
    input  logic              aborta,
    input  logic              servo_pronto,
    output logic              aciona,
    output logic [MOVE_W-1:0] movimento,
    output logic              passo_pronto,
    output logic              pronto,
    output logic              abortado,
    output logic              ocupado,
    output logic [ADDR_W:0]   num_movimentos,
    output logic              cheio,
    output logic              overflow,
    output logic [2:0]        db_estado
);

    estado_t           estado;
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [MOVE_W-1:0] rd_data;
    logic              aborta_lat;
    logic              pausa_lat;
    logic              wr_en;

    assign cheio          = (wr_ptr == (ADDR_W+1)'(DEPTH));
    assign wr_ready       = (estado == OCIOSO) && !cheio;
    assign wr_en          = wr_valid && wr_ready && !zera;
    assign num_movimentos = wr_ptr;
    assign ocupado        = (estado != OCIOSO);
    assign db_estado      = estado;

    ram_sincrona #(
        .DEPTH  (DEPTH),
        .MOVE_W (MOVE_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (wr_data),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (rd_data)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado       <= OCIOSO;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            movimento    <= '0;
            aborta_lat   <= 1'b0;
            pausa_lat    <= 1'b0;
            overflow     <= 1'b0;
            aciona       <= 1'b0;
            passo_pronto <= 1'b0;
            pronto       <= 1'b0;
            abortado     <= 1'b0;
        end else begin
            aciona       <= 1'b0;
            passo_pronto <= 1'b0;
            pronto       <= 1'b0;
            abortado     <= 1'b0;

            // Requests are remembered so a move in flight always completes.
            if (estado != OCIOSO) begin
                if (aborta) aborta_lat <= 1'b1;
                if (pausa)  pausa_lat  <= 1'b1;
            end

            case (estado)
                OCIOSO: begin
                    if (zera) begin
                        wr_ptr   <= '0;
                        rd_ptr   <= '0;
                        overflow <= 1'b0;
                    end else begin
                        if (wr_en) begin
                            wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
                        end else if (wr_valid && cheio) begin
                            overflow <= 1'b1;
                        end
                        if (iniciar) estado <= LE;
                    end
                end
                LE: estado <= VERIFICA;
                VERIFICA: begin
                    if (rd_ptr == wr_ptr || rd_data == MOVE_W'(END_CODE)) begin
                        pronto <= 1'b1;
                        estado <= FIM;
                    end else begin
                        movimento <= rd_data;
                        aciona    <= 1'b1;
                        estado    <= ACIONA;
                    end
                end
                ACIONA: estado <= ESPERA;
                ESPERA: begin
                    if (servo_pronto) begin
                        rd_ptr       <= rd_ptr + (ADDR_W+1)'(1);
                        passo_pronto <= 1'b1;
                        aborta_lat   <= 1'b0;
                        pausa_lat    <= 1'b0;
                        if (aborta_lat || aborta) begin
                            pronto   <= 1'b1;
                            abortado <= 1'b1;
                            estado   <= FIM;
                        end else if (pausa_lat || pausa) begin
                            estado <= PAUSADO;
                        end else if (modo_passo) begin
                            estado <= OCIOSO;
                        end else begin
                            estado <= LE;
                        end
                    end
                end
                PAUSADO: begin
                    if (aborta || aborta_lat) begin
                        pronto     <= 1'b1;
                        abortado   <= 1'b1;
                        aborta_lat <= 1'b0;
                        pausa_lat  <= 1'b0;
                        estado     <= FIM;
                    end else if (iniciar) begin
                        pausa_lat <= 1'b0;
                        estado    <= LE;
                    end
                end
                FIM: begin
                    rd_ptr     <= '0;
                    aborta_lat <= 1'b0;
                    pausa_lat  <= 1'b0;
                    estado     <= OCIOSO;
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_sequenciador_movimentos.sv
// Scoreboard bench for sequenciador_movimentos: a list-level model predicts the servo handshake events.
module tb_sequenciador_movimentos;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned ADDR_W   = 2;
    localparam int unsigned MOVE_W   = 3;
    localparam int unsigned END_CODE = 0;

    localparam int EV_ACIONA = 0;
    localparam int EV_PASSO  = 1;
    localparam int EV_PRONTO = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              zera = 1'b0;
    logic              wr_valid = 1'b0;
    logic [MOVE_W-1:0] wr_data = '0;
    logic              wr_ready;
    logic              iniciar = 1'b0;
    logic              modo_passo = 1'b0;
    logic              pausa = 1'b0;
    logic              aborta = 1'b0;
    logic              servo_pronto = 1'b0;
    logic              aciona;
    logic [MOVE_W-1:0] movimento;
    logic              passo_pronto;
    logic              pronto;
    logic              abortado;
    logic              ocupado;
    logic [ADDR_W:0]   num_movimentos;
    logic              cheio;
    logic              overflow;
    logic [2:0]        db_estado;

    sequenciador_movimentos #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .MOVE_W   (MOVE_W),
        .END_CODE (END_CODE)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .zera           (zera),
        .wr_valid       (wr_valid),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready),
        .iniciar        (iniciar),
        .modo_passo     (modo_passo),
        .pausa          (pausa),
        .aborta         (aborta),
        .servo_pronto   (servo_pronto),
        .aciona         (aciona),
        .movimento      (movimento),
        .passo_pronto   (passo_pronto),
        .pronto         (pronto),
        .abortado       (abortado),
        .ocupado        (ocupado),
        .num_movimentos (num_movimentos),
        .cheio          (cheio),
        .overflow       (overflow),
        .db_estado      (db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    ev_t sb[$];
    int  checks = 0;
    int  errors = 0;

    // Reference model: the stored list, its length, the replay position, overflow flag.
    int  m_mem[DEPTH];
    int  m_count = 0;
    int  m_rd = 0;
    bit  m_ovf = 1'b0;
    int  srv_fixed = 4;
    int  resets = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input int val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input int kind, input int val);
        ev_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL evento_inesperado: got kind %0d val %0d expected none", kind, val);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.val != val) begin
                errors++;
                $display("FAIL evento: got kind %0d val %0d expected kind %0d val %0d",
                         kind, val, e.kind, e.val);
            end
        end
    endtask

    // Monitor: passo and pronto may share a cycle on abort; passo comes first.
    always @(negedge clock) begin
        if (passo_pronto) pop_cmp(EV_PASSO, 0);
        if (pronto)       pop_cmp(EV_PRONTO, int'(abortado));
        if (aciona)       pop_cmp(EV_ACIONA, int'(movimento));
    end

    // Servo manager stand-in: answers every aciona after a delay, checking movimento stays put.
    initial begin
        forever begin
            @(negedge clock);
            if (aciona) begin
                automatic int d = (srv_fixed != 0) ? srv_fixed : int'($urandom_range(1, 6));
                automatic int mv = int'(movimento);
                automatic int r0 = resets;
                repeat (d) @(negedge clock);
                if (resets == r0) check("movimento_estavel", int'(movimento), mv);
                servo_pronto = 1'b1;
                @(negedge clock);
                servo_pronto = 1'b0;
            end
        end
    end

    task automatic write_move(input int v);
        @(negedge clock);
        wr_valid = 1'b1;
        wr_data  = MOVE_W'(v);
        if (m_count < int'(DEPTH)) begin
            m_mem[m_count] = v;
            m_count++;
        end else begin
            m_ovf = 1'b1;
        end
        @(negedge clock);
        wr_valid = 1'b0;
    endtask

    task automatic do_zera();
        @(negedge clock);
        zera = 1'b1;
        @(negedge clock);
        zera = 1'b0;
        m_count = 0;
        m_rd    = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic start();
        @(negedge clock);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
    endtask

    // One iniciar: in run mode plays until end/terminator, in step mode one move.
    task automatic expect_run(input bit step, output bit fim);
        fim = 1'b0;
        while (1) begin
            if (m_rd == m_count || m_mem[m_rd] == int'(END_CODE)) begin
                push(EV_PRONTO, 0);
                m_rd = 0;
                fim  = 1'b1;
                return;
            end
            push(EV_ACIONA, m_mem[m_rd]);
            push(EV_PASSO, 0);
            m_rd++;
            if (step) return;
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((sb.size() != 0 || db_estado != 3'd0) && n < 300) begin
            @(negedge clock);
            n++;
        end
        check({name, "_concluido"}, int'(n < 300), 1);
    endtask

    task automatic wait_aciona(input string name);
        int n = 0;
        while (!aciona && n < 100) begin
            @(negedge clock);
            n++;
        end
        check({name, "_viu_aciona"}, int'(aciona), 1);
    endtask

    task automatic check_store(input string name);
        check({name, "_num"}, int'(num_movimentos), m_count);
        check({name, "_cheio"}, int'(cheio), int'(m_count == int'(DEPTH)));
        check({name, "_overflow"}, int'(overflow), int'(m_ovf));
    endtask

    initial begin
        bit fim;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit fim;
        int n;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        check("reset_estado", int'(db_estado), 0);
        check("reset_ocupado", int'(ocupado), 0);
        check("reset_wr_ready", int'(wr_ready), 1);
        check("reset_pulsos", int'({aciona, passo_pronto, pronto, abortado}), 0);
        check("reset_movimento", int'(movimento), 0);
        check_store("reset");

        // Three moves, servo answers 4 cycles after each aciona; then replay without reload.
        write_move(3); write_move(5); write_move(1);
        check_store("carga_351");
        expect_run(1'b0, fim); start(); wait_idle("run_351");
        expect_run(1'b0, fim); start(); wait_idle("replay_351");

        // Terminator in the middle stops the sequence.
        do_zera();
        write_move(2); write_move(int'(END_CODE)); write_move(4);
        expect_run(1'b0, fim); start(); wait_idle("run_end_code");

        // Overflow on a full store, then zera.
        do_zera();
        for (int i = 0; i < 5; i++) write_move(int'($urandom_range(1, 7)));
        check_store("cheio");
        check("cheio_wr_ready", int'(wr_ready), 0);
        do_zera();
        check_store("zera");

        // Empty store: pronto with no aciona.
        expect_run(1'b0, fim); start(); wait_idle("vazio");

        // Step mode, two moves, three iniciar.
        modo_passo = 1'b1;
        write_move(6); write_move(2);
        for (int i = 0; i < 3; i++) begin
            expect_run(1'b1, fim); start(); wait_idle("passo");
        end
        check("passo_fim_no_terceiro", int'(fim), 1);
        modo_passo = 1'b0;

        // Abort during the first move.
        do_zera();
        write_move(1); write_move(2); write_move(3);
        push(EV_ACIONA, 1); push(EV_PASSO, 0); push(EV_PRONTO, 1);
        start(); wait_aciona("aborta");
        @(negedge clock); aborta = 1'b1;
        @(negedge clock); aborta = 1'b0;
        wait_idle("aborta");
        m_rd = 0;

        // Pause mid-move, ignored write while paused, resume at move 2.
        push(EV_ACIONA, 1); push(EV_PASSO, 0);
        m_rd = 1;
        start(); wait_aciona("pausa");
        @(negedge clock); pausa = 1'b1;
        @(negedge clock); pausa = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 100) begin @(negedge clock); n++; end
        @(negedge clock);
        check("pausa_estado", int'(db_estado), 5);
        check("pausa_ocupado", int'(ocupado), 1);
        wr_valid = 1'b1; wr_data = 3'd7;
        @(negedge clock); wr_valid = 1'b0;
        check_store("escrita_em_pausa");
        expect_run(1'b0, fim); start(); wait_idle("retoma");

        // Randomised loads and runs in either mode.
        srv_fixed = 0;
        for (int it = 0; it < 10; it++) begin
            automatic bit step = 1'($urandom_range(0, 1));
            do_zera();
            n = int'($urandom_range(0, 5));
            for (int k = 0; k < n; k++) write_move(int'($urandom_range(0, 7)));
            check_store("aleatorio_carga");
            modo_passo = step;
            fim = 1'b0;
            for (int k = 0; k < 6 && !fim; k++) begin
                expect_run(step, fim); start(); wait_idle("aleatorio");
            end
            check("aleatorio_terminou", int'(fim), 1);
        end
        modo_passo = 1'b0;
        srv_fixed = 4;

        // Reset while waiting on the servo abandons the move.
        do_zera();
        write_move(4); write_move(5);
        push(EV_ACIONA, 4);
        start(); wait_aciona("reset_meio");
        @(negedge clock);
        check("reset_meio_espera", int'(db_estado), 4);
        resets++;
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        m_count = 0; m_rd = 0; m_ovf = 1'b0;
        check("reset_meio_estado", int'(db_estado), 0);
        repeat (10) @(negedge clock);
        check("reset_meio_sem_eventos", sb.size(), 0);
        check("reset_meio_ocioso", int'(db_estado), 0);
        check_store("reset_meio");

        check("scoreboard_vazio", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
